// File: rtl/video_pkg.sv
// Shared video path definitions: FSM encodings,
// pixel packing offsets and the FIFO word layout.
package video_pkg;

  localparam int AXIS_DW   = 32;
  localparam int RED_LSB   = 0;
  localparam int GREEN_LSB = 8;
  localparam int BLUE_LSB  = 16;

  typedef enum logic [2:0] {
    CAP_IDLE,
    CAP_WAIT_VS,
    CAP_WAIT_DE,
    CAP_CAPTURE,
    CAP_TERM
  } cap_state_t;

  typedef enum logic [1:0] {
    DSP_IDLE,
    DSP_WAIT_SOF,
    DSP_ACTIVE,
    DSP_FLUSH
  } dsp_state_t;

  typedef struct packed {
    logic       tuser;
    logic       tlast;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } cap_word_t;

  function automatic logic [AXIS_DW-1:0] pack_pixel(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    logic [AXIS_DW-1:0] d;
    d = '0;
    d[RED_LSB+:8]   = r;
    d[GREEN_LSB+:8] = g;
    d[BLUE_LSB+:8]  = b;
    return d;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock show-ahead FIFO with registered
// full/empty flags.
module axis_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_d;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];

  always_comb begin
    count_d = count;
    if (wr_en && !rd_en)
      count_d = count + 1'b1;
    else if (!wr_en && rd_en)
      count_d = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
      full  <= (count_d == CNT_FULL);
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/video_axis_capture.sv
// Parallel video to AXI-Stream frame capture:
// one frame per packet, always closed by tlast.
module video_axis_capture
  import video_pkg::*;
#(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int FIFO_DEPTH = 16,
  parameter bit VSYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               clr_status,
  input  logic [7:0]         vid_red,
  input  logic [7:0]         vid_green,
  input  logic               vid_blank,
  input  logic [7:0]         vid_blue,
  input  logic               vid_vsync,
  output logic [AXIS_DW-1:0] m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               m_tuser,
  output logic               overflow,
  output logic               short_frame,
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  localparam int TOTAL = H_VISIBLE * V_VISIBLE;
  localparam int CNT_W = $clog2(TOTAL);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TOTAL - 1);
  localparam int FW = $bits(cap_word_t);

  logic [7:0]  red_q;
  logic [7:0]  green_q;
  logic [7:0]  blue_q;
  logic        blank_q;
  logic        vs_q;
  logic        vs_q2;
  logic        vs_edge;

  cap_state_t      state_q;
  cap_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic            push;
  cap_word_t       push_word;
  logic            ovf_set;
  logic            short_set;
  logic            frame_done;

  logic            fifo_full;
  logic            fifo_empty;
  logic [FW-1:0]   fifo_dout;
  cap_word_t       head;

  // Input stage aligns pixel data with the vsync edge detector.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      blank_q <= 1'b1;
      vs_q    <= ~VSYNC_POL;
      vs_q2   <= ~VSYNC_POL;
    end else begin
      red_q   <= vid_red;
      green_q <= vid_green;
      blue_q  <= vid_blue;
      blank_q <= vid_blank;
      vs_q    <= vid_vsync;
      vs_q2   <= vs_q;
    end
  end

  assign vs_edge = (vs_q == VSYNC_POL) &&
                   (vs_q2 != VSYNC_POL);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= CAP_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_word  = '0;
    ovf_set    = 1'b0;
    short_set  = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      CAP_IDLE: begin
        if (enable)
          state_d = CAP_WAIT_VS;
      end
      CAP_WAIT_VS: begin
        if (!enable)
          state_d = CAP_IDLE;
        else if (vs_edge)
          state_d = CAP_WAIT_DE;
      end
      CAP_WAIT_DE: begin
        if (!enable) begin
          state_d = CAP_IDLE;
        end else if (!blank_q) begin
          if (fifo_full) begin
            ovf_set = 1'b1;
            cnt_d   = '0;
            state_d = CAP_TERM;
          end else begin
            push            = 1'b1;
            push_word.tuser = 1'b1;
            push_word.r     = red_q;
            push_word.g     = green_q;
            push_word.b     = blue_q;
            cnt_d           = CNT_W'(1);
            state_d         = CAP_CAPTURE;
          end
        end
      end
      CAP_CAPTURE: begin
        if (vs_edge) begin
          short_set = 1'b1;
          cnt_d     = '0;
          state_d   = CAP_TERM;
        end else if (!blank_q) begin
          if (fifo_full) begin
            ovf_set = 1'b1;
            cnt_d   = '0;
            state_d = CAP_TERM;
          end else begin
            push        = 1'b1;
            push_word.r = red_q;
            push_word.g = green_q;
            push_word.b = blue_q;
            if (cnt_q == CNT_LAST) begin
              push_word.tlast = 1'b1;
              cnt_d           = '0;
              frame_done      = 1'b1;
              state_d = enable ? CAP_WAIT_VS
                               : CAP_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      CAP_TERM: begin
        if (!fifo_full) begin
          push            = 1'b1;
          push_word.tlast = 1'b1;
          state_d = enable ? CAP_WAIT_VS
                           : CAP_IDLE;
        end
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  // Set events take priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow    <= 1'b0;
      short_frame <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (ovf_set)
        overflow <= 1'b1;
      else if (clr_status)
        overflow <= 1'b0;
      if (short_set)
        short_frame <= 1'b1;
      else if (clr_status)
        short_frame <= 1'b0;
      if (frame_done)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  axis_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (push_word),
    .full  (fifo_full),
    .pop   (m_tvalid & m_tready),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign head     = fifo_dout;
  assign m_tvalid = ~fifo_empty;
  assign m_tlast  = ~fifo_empty & head.tlast;
  assign m_tuser  = ~fifo_empty & head.tuser;
  assign m_tdata  = fifo_empty ? '0 :
    pack_pixel(head.r, head.g, head.b);
  assign busy     = (state_q != CAP_IDLE);

endmodule

// File: tb/tb_video_axis_capture.sv
// Directed scenario bench with random pixel data
// and a frame-level reference model.
module tb_video_axis_capture;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int TOT   = H * V;
  localparam int DEPTH = 4;
  localparam logic [33:0] TERM_W = 34'h1_0000_0000;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic        clr_status;
  logic [7:0]  vid_red;
  logic [7:0]  vid_green;
  logic        vid_blank;
  logic [7:0]  vid_blue;
  logic        vid_vsync;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
  logic        overflow;
  logic        short_frame;
  logic        busy;
  logic [15:0] frame_cnt;

  video_axis_capture #(
    .H_VISIBLE  (H),
    .V_VISIBLE  (V),
    .FIFO_DEPTH (DEPTH),
    .VSYNC_POL  (1'b0)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .clr_status  (clr_status),
    .vid_red     (vid_red),
    .vid_green   (vid_green),
    .vid_blank   (vid_blank),
    .vid_blue    (vid_blue),
    .vid_vsync   (vid_vsync),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .overflow    (overflow),
    .short_frame (short_frame),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [33:0] expq[$];
  logic [33:0] rcvq[$];
  int          cidx;

  bit m_en;
  bit m_cap;
  int m_cnt;
  int m_fc;
  bit m_ovf;
  bit m_short;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h",
             tag, obs, expv);
    end
  endtask

  function automatic int occ();
    return expq.size() - rcvq.size();
  endfunction

  task automatic m_reset();
    expq.delete();
    rcvq.delete();
    cidx    = 0;
    m_cap   = 0;
    m_cnt   = 0;
    m_fc    = 0;
    m_ovf   = 0;
    m_short = 0;
  endtask

  task automatic m_vsync();
    if (occ() > DEPTH)
      return;
    if (m_cap && m_cnt > 0) begin
      m_short = 1;
      m_cap   = 0;
      expq.push_back(TERM_W);
    end else if (m_en) begin
      m_cap = 1;
      m_cnt = 0;
    end
  endtask

  task automatic m_pixel(input logic [31:0] d);
    if (!m_cap)
      return;
    if (occ() >= DEPTH) begin
      m_ovf = 1;
      m_cap = 0;
      expq.push_back(TERM_W);
      return;
    end
    m_cnt++;
    expq.push_back({m_cnt == 1, m_cnt == TOT, d});
    if (m_cnt == TOT) begin
      m_cap = 0;
      m_fc  = (m_fc + 1) % 65536;
    end
  endtask

  task automatic set_en(input bit v);
    enable = v;
    m_en   = v;
    if (!v && m_cap && m_cnt == 0)
      m_cap = 0;
  endtask

  logic [33:0] hold_w;
  bit          hold_v = 0;

  always @(negedge clk) begin
    if (rstn && m_tvalid) begin
      if (hold_v)
        chk("hold", 64'({m_tuser, m_tlast, m_tdata}),
            64'(hold_w));
      if (m_tready)
        rcvq.push_back({m_tuser, m_tlast, m_tdata});
      hold_v = !m_tready;
      hold_w = {m_tuser, m_tlast, m_tdata};
    end else begin
      hold_v = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int i, input bit idx);
    logic [7:0] r, g, b;
    if (idx) begin
      r = i[7:0];
      g = 8'h00;
      b = 8'h00;
    end else begin
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
    end
    vid_red   = r;
    vid_green = g;
    vid_blue  = b;
    vid_blank = 1'b0;
    m_pixel({8'h00, b, g, r});
    tick();
    vid_blank = 1'b1;
  endtask

  task automatic pixels(input int from, input int to,
                        input bit idx, input bit gaps);
    for (int i = from; i <= to; i++) begin
      pix(i, idx);
      if (gaps)
        repeat ($urandom_range(0, 2)) tick();
      if ((i % H) == H - 1)
        repeat (2) tick();
    end
  endtask

  task automatic vsync();
    vid_blank = 1'b1;
    m_vsync();
    vid_vsync = 1'b0;
    repeat (2) tick();
    vid_vsync = 1'b1;
    repeat (3) tick();
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (rcvq.size() < expq.size() && t < 400) begin
      tick();
      t++;
    end
    repeat (4) tick();
    chk({tag, " count"}, 64'(rcvq.size()),
        64'(expq.size()));
    for (int k = cidx; k < expq.size(); k++)
      if (k < rcvq.size())
        chk($sformatf("%s word%0d", tag, k - cidx),
            64'(rcvq[k]), 64'(expq[k]));
    cidx = expq.size();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " tvalid"}, 64'(m_tvalid), 64'(0));
    chk({tag, " tlast"}, 64'(m_tlast), 64'(0));
    chk({tag, " tuser"}, 64'(m_tuser), 64'(0));
    chk({tag, " tdata"}, 64'(m_tdata), 64'(0));
    chk({tag, " ovf"}, 64'(overflow), 64'(0));
    chk({tag, " short"}, 64'(short_frame), 64'(0));
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " fcnt"}, 64'(frame_cnt), 64'(0));
  endtask

  task automatic chk_status(input string tag);
    chk({tag, " ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, " short"}, 64'(short_frame),
        64'(m_short));
    chk({tag, " fcnt"}, 64'(frame_cnt), 64'(m_fc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rstn       = 1'b0;
    enable     = 1'b0;
    clr_status = 1'b0;
    vid_red    = '0;
    vid_green  = '0;
    vid_blue   = '0;
    vid_blank  = 1'b1;
    vid_vsync  = 1'b1;
    m_tready   = 1'b1;
    m_en       = 0;
    m_reset();
    repeat (3) tick();
    check_reset("reset");
    rstn = 1'b1;
    tick();

    // Normal frame, red = pixel index.
    set_en(1);
    tick();
    chk("s1 busy", 64'(busy), 64'(1));
    vsync();
    pix(0, 1);
    chk("s1 lat0", 64'(m_tvalid), 64'(0));
    tick();
    chk("s1 lat1", 64'({m_tvalid, m_tuser, m_tdata}),
        64'({1'b1, 1'b1, 32'h0}));
    pixels(1, TOT - 1, 1, 1);
    drain("s1");
    chk("s1 w0", 64'(rcvq[0]), 64'({2'b10, 32'h0}));
    chk("s1 w31", 64'(rcvq[31]), 64'({2'b01, 32'h1F}));
    chk_status("s1");

    // Backpressure: overflow on the fifth pixel.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m_reset();
    tick();
    m_tready = 1'b0;
    vsync();
    pixels(0, 3, 0, 1);
    repeat (3) tick();
    chk("s2 ovf pre", 64'(overflow), 64'(0));
    pixels(4, 4, 0, 0);
    repeat (3) tick();
    chk("s2 ovf post", 64'(overflow), 64'(1));
    pixels(5, TOT - 1, 0, 1);
    repeat (3) tick();
    chk("s2 stalled", 64'(rcvq.size()), 64'(0));
    chk("s2 tvalid", 64'(m_tvalid), 64'(1));
    m_tready = 1'b1;
    drain("s2");
    chk("s2 n", 64'(rcvq.size()), 64'(5));
    chk("s2 term", 64'(rcvq[4]), 64'(TERM_W));
    chk_status("s2");

    // Short frame, skipped frame, then a full one.
    vsync();
    pixels(0, 19, 0, 1);
    vsync();
    pixels(0, TOT - 1, 0, 1);
    vsync();
    pixels(0, TOT - 1, 0, 1);
    drain("s3");
    chk("s3 n", 64'(rcvq.size()), 64'(5 + 21 + TOT));
    chk_status("s3");

    // Stop mid-frame, then clear sticky flags.
    vsync();
    pixels(0, 9, 0, 1);
    set_en(0);
    pixels(10, TOT - 1, 0, 1);
    drain("s4");
    chk("s4 busy", 64'(busy), 64'(0));
    vsync();
    pixels(0, TOT - 1, 0, 1);
    drain("s4 idle");
    chk_status("s4");
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    m_ovf   = 0;
    m_short = 0;
    tick();
    chk_status("s4 clr");

    // Late start waits for the next vsync.
    vsync();
    pixels(0, 11, 0, 1);
    set_en(1);
    pixels(12, TOT - 1, 0, 1);
    repeat (3) tick();
    chk("s5 quiet", 64'(rcvq.size()),
        64'(expq.size()));
    base = rcvq.size();
    vsync();
    pixels(0, TOT - 1, 0, 1);
    drain("s5");
    chk("s5 sof", 64'(rcvq[base][33]), 64'(1));
    chk("s5 n", 64'(rcvq.size() - base), 64'(TOT));
    chk_status("s5");

    // Reset with words queued under backpressure.
    vsync();
    pixels(0, 11, 0, 1);
    drain("s6 pre");
    m_tready = 1'b0;
    pixels(12, 14, 0, 0);
    repeat (3) tick();
    chk("s6 queued", 64'(m_tvalid), 64'(1));
    chk("s6 occ", 64'(occ()), 64'(3));
    rstn = 1'b0;
    tick();
    check_reset("s6 rst");
    m_reset();
    rstn     = 1'b1;
    m_tready = 1'b1;
    tick();
    pixels(15, TOT - 1, 0, 1);
    repeat (3) tick();
    chk("s6 quiet", 64'(rcvq.size()), 64'(0));
    vsync();
    pixels(0, TOT - 1, 0, 1);
    drain("s6");
    chk("s6 sof", 64'(rcvq[0][33]), 64'(1));
    chk_status("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
